// File: rtl/display_mode_controller.sv
// Display mode controller: arbitrates between the stopwatch and countdown engines.
// Synchronises the mode slide switch, runs a settle window on every mode change, steers
// debounced button pulses to the active engine, selects the display source, raises a
// blinking alarm on countdown time-out and blinks the digits under countdown edit.
module display_mode_controller #(
  parameter int unsigned SETTLE_TICKS = 2,
  parameter int unsigned BLINK_TICKS  = 50,
  parameter int unsigned ALARM_TICKS  = 500
) (
  input  logic       clk_core,
  input  logic       rst_n,
  input  logic       mode_switch,
  input  logic       left_p,
  input  logic       right_p,
  input  logic       center_p,
  input  logic       up_p,
  input  logic       down_p,
  input  logic [7:0] sw_min_i,
  input  logic [7:0] sw_sec_i,
  input  logic [7:0] cd_min_i,
  input  logic [7:0] cd_sec_i,
  input  logic [1:0] cd_target_i,
  input  logic       cd_time_out_i,
  output logic       sw_rst_o,
  output logic       sw_pause_o,
  output logic       sw_record_o,
  output logic       cd_left_o,
  output logic       cd_right_o,
  output logic       cd_center_o,
  output logic       cd_up_o,
  output logic       cd_down_o,
  output logic [7:0] disp_min_o,
  output logic [7:0] disp_sec_o,
  output logic [3:0] blank_mask_o,
  output logic       active_mode_o,
  output logic       alarm_o
);

  localparam int unsigned SettleW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam int unsigned BlinkW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned AlarmW  = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_TICKS - 1);
  localparam logic [BlinkW-1:0]  BlinkLast  = BlinkW'(BLINK_TICKS - 1);
  localparam logic [AlarmW-1:0]  AlarmLast  = AlarmW'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    StSw,
    StCd,
    StSwitch,
    StAlarm
  } state_e;

  // FSM state and its counters
  state_e               state_q, state_d;
  logic                 tgt_q, tgt_d;            // SWITCH destination: 0 = SW, 1 = CD
  logic [SettleW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [AlarmW-1:0]    alarm_cnt_q, alarm_cnt_d;
  logic                 active_mode_q, active_mode_d;

  // Mode switch synchroniser
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 mode_s;

  // Time-out edge detect and deferred alarm
  logic                 tout_prev_q, tout_prev_d;
  logic                 alarm_pending_q, alarm_pending_d;
  logic                 tout_rise;

  // Blink generator
  logic [BlinkW-1:0]    blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;

  // Registered command and display outputs
  logic [2:0]           sw_cmd_q, sw_cmd_d;      // {rst, pause, record}
  logic [4:0]           cd_cmd_q, cd_cmd_d;      // {left, right, center, up, down}
  logic [7:0]           disp_min_q, disp_min_d;
  logic [7:0]           disp_sec_q, disp_sec_d;

  logic                 any_btn;
  logic                 enter_blink_state;

  assign mode_s    = sync2_q;
  assign tout_rise = cd_time_out_i & ~tout_prev_q;
  assign any_btn   = left_p | right_p | center_p | up_p | down_p;

  // FSM state register with synchronous active-low reset
  always_ff @(posedge clk_core) begin
    if (!rst_n) begin
      state_q       <= StSw;
      tgt_q         <= 1'b0;
      settle_cnt_q  <= '0;
      alarm_cnt_q   <= '0;
      active_mode_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      settle_cnt_q  <= settle_cnt_d;
      alarm_cnt_q   <= alarm_cnt_d;
      active_mode_q <= active_mode_d;
    end
  end

  // FSM next-state: mode changes always win, then alarm entry/exit
  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    settle_cnt_d  = settle_cnt_q;
    alarm_cnt_d   = alarm_cnt_q;
    active_mode_d = active_mode_q;
    unique case (state_q)
      StSw: begin
        if (mode_s) begin
          state_d      = StSwitch;
          tgt_d        = 1'b1;
          settle_cnt_d = '0;
        end
      end
      StCd: begin
        if (!mode_s) begin
          state_d      = StSwitch;
          tgt_d        = 1'b0;
          settle_cnt_d = '0;
        end else if (tout_rise || alarm_pending_q) begin
          state_d     = StAlarm;
          alarm_cnt_d = '0;
        end
      end
      StSwitch: begin
        if (mode_s != tgt_q) begin
          // Switch moved again before settling: chase the new position from scratch
          tgt_d        = mode_s;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SettleLast) begin
          state_d       = tgt_q ? StCd : StSw;
          active_mode_d = tgt_q;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      StAlarm: begin
        if (!mode_s) begin
          state_d      = StSwitch;
          tgt_d        = 1'b0;
          settle_cnt_d = '0;
        end else if (any_btn) begin
          state_d = StCd;
        end else if (alarm_cnt_q == AlarmLast) begin
          state_d = StCd;
        end else begin
          alarm_cnt_d = alarm_cnt_q + 1'b1;
        end
      end
      default: state_d = StSw;
    endcase
  end

  // FSM outputs: alarm flag, committed mode and digit blanking
  always_comb begin
    alarm_o       = (state_q == StAlarm);
    active_mode_o = active_mode_q;
    blank_mask_o  = 4'b0000;
    if (phase_q) begin
      case (state_q)
        StCd: begin
          case (cd_target_i)
            2'b00:   blank_mask_o = 4'b1100;
            2'b01:   blank_mask_o = 4'b0011;
            default: blank_mask_o = 4'b0000;
          endcase
        end
        StAlarm: blank_mask_o = 4'b1111;
        default: blank_mask_o = 4'b0000;
      endcase
    end
  end

  // Datapath next-state: synchroniser, time-out tracking, blink, routing and display
  always_comb begin
    sync1_d     = mode_switch;
    sync2_d     = sync1_q;
    tout_prev_d = cd_time_out_i;

    // Entering ALARM consumes the deferred alarm; a rise seen away from CD/ALARM defers one
    alarm_pending_d = alarm_pending_q;
    if (state_d == StAlarm && state_q != StAlarm) begin
      alarm_pending_d = 1'b0;
    end else if (tout_rise && state_q != StCd && state_q != StAlarm) begin
      alarm_pending_d = 1'b1;
    end

    // Restart the blink on entry so the first half-period is always fully visible
    enter_blink_state = (state_d != state_q) && (state_d == StCd || state_d == StAlarm);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (enter_blink_state) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    // Pulses in SWITCH/ALARM are dropped; an ALARM acknowledge is never forwarded
    sw_cmd_d = 3'b000;
    cd_cmd_d = 5'b00000;
    case (state_q)
      StSw:    sw_cmd_d = {right_p, center_p, left_p};
      StCd:    cd_cmd_d = {left_p, right_p, center_p, up_p, down_p};
      default: ;
    endcase

    disp_min_d = disp_min_q;
    disp_sec_d = disp_sec_q;
    case (state_q)
      StSw: begin
        disp_min_d = sw_min_i;
        disp_sec_d = sw_sec_i;
      end
      StCd, StAlarm: begin
        disp_min_d = cd_min_i;
        disp_sec_d = cd_sec_i;
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous active-low reset
  always_ff @(posedge clk_core) begin
    if (!rst_n) begin
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      tout_prev_q     <= 1'b0;
      alarm_pending_q <= 1'b0;
      blink_cnt_q     <= '0;
      phase_q         <= 1'b0;
      sw_cmd_q        <= 3'b000;
      cd_cmd_q        <= 5'b00000;
      disp_min_q      <= 8'h00;
      disp_sec_q      <= 8'h00;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      tout_prev_q     <= tout_prev_d;
      alarm_pending_q <= alarm_pending_d;
      blink_cnt_q     <= blink_cnt_d;
      phase_q         <= phase_d;
      sw_cmd_q        <= sw_cmd_d;
      cd_cmd_q        <= cd_cmd_d;
      disp_min_q      <= disp_min_d;
      disp_sec_q      <= disp_sec_d;
    end
  end

  assign {sw_rst_o, sw_pause_o, sw_record_o}                    = sw_cmd_q;
  assign {cd_left_o, cd_right_o, cd_center_o, cd_up_o, cd_down_o} = cd_cmd_q;
  assign disp_min_o = disp_min_q;
  assign disp_sec_o = disp_sec_q;

endmodule
